// File: rtl/sync_queue.sv
// sync_queue: single-clock first-word-fall-through queue with occupancy count,
// almost-full / almost-empty thresholds and sticky overflow / underflow flags.
// Storage is a register array that is never reset; only pointers, count and
// flags are reset or flushed.
module sync_queue #(
   parameter int BITSIZE = 8,
   parameter int ADDSIZE = 4,
   parameter int AF_LVL  = 2**ADDSIZE-2,
   parameter int AE_LVL  = 2
) (
   input  logic               CLK,
   input  logic               RSTN,
   input  logic               CLR,
   input  logic               PUS,
   input  logic               POP,
   input  logic [BITSIZE-1:0] DI,
   output logic [BITSIZE-1:0] DO,
   output logic               DF,
   output logic               FUL,
   output logic               AF,
   output logic               AE,
   output logic [ADDSIZE:0]   CNT,
   output logic               OVF,
   output logic               UDF
);

   localparam int DEPTH = 2**ADDSIZE;

   localparam logic [ADDSIZE:0]   DEPTH_C = (ADDSIZE+1)'(DEPTH);
   localparam logic [ADDSIZE:0]   AF_C    = (ADDSIZE+1)'(AF_LVL);
   localparam logic [ADDSIZE:0]   AE_C    = (ADDSIZE+1)'(AE_LVL);
   localparam logic [ADDSIZE:0]   CNT_ONE = (ADDSIZE+1)'(1);
   localparam logic [ADDSIZE-1:0] PTR_ONE = ADDSIZE'(1);

   // Reject illegal configurations while the design is being elaborated.
   if (BITSIZE < 1) begin : g_chk_bitsize
      $fatal(1, "sync_queue: BITSIZE must be >= 1");
   end
   if (ADDSIZE < 1) begin : g_chk_addsize
      $fatal(1, "sync_queue: ADDSIZE must be >= 1");
   end
   if (AF_LVL < 1 || AF_LVL > DEPTH) begin : g_chk_af
      $fatal(1, "sync_queue: AF_LVL must be in 1..DEPTH");
   end
   if (AE_LVL < 0 || AE_LVL > DEPTH-1) begin : g_chk_ae
      $fatal(1, "sync_queue: AE_LVL must be in 0..DEPTH-1");
   end

   // Request semantics: PUS and POP are level requests sampled on every rising
   // CLK; each asserted cycle is one attempt. A pop is taken only when a word
   // is present (DF=1). A push is taken when the queue is not full, or when a
   // pop is taken in the same cycle (a slot frees up on that edge). Refused
   // attempts leave the queue untouched and set the matching sticky flag.
   // CLR beats both requests in the cycle it is high.

   logic [BITSIZE-1:0] mem_q [DEPTH];

   logic [ADDSIZE-1:0] head_q, head_d;
   logic [ADDSIZE-1:0] rear_q, rear_d;
   logic [ADDSIZE:0]   cnt_q,  cnt_d;
   logic               ovf_q,  ovf_d;
   logic               udf_q,  udf_d;

   logic               not_empty;
   logic               is_full;
   logic               pop_acc;
   logic               push_acc;
   logic               wr_en;

   // Status derived purely from the registered count.
   always_comb begin
      not_empty = (cnt_q != '0);
      is_full   = (cnt_q == DEPTH_C);
   end

   // Acceptance decisions, next-state for pointers, count and sticky flags.
   always_comb begin
      head_d   = head_q;
      rear_d   = rear_q;
      cnt_d    = cnt_q;
      ovf_d    = ovf_q;
      udf_d    = udf_q;
      pop_acc  = POP & not_empty;
      push_acc = PUS & (~is_full | pop_acc);
      wr_en    = 1'b0;

      if (CLR) begin
         head_d = '0;
         rear_d = '0;
         cnt_d  = '0;
         ovf_d  = 1'b0;
         udf_d  = 1'b0;
      end else begin
         if (pop_acc) begin
            head_d = head_q + PTR_ONE;
         end
         if (push_acc) begin
            rear_d = rear_q + PTR_ONE;
            wr_en  = 1'b1;
         end
         case ({push_acc, pop_acc})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
         endcase
         if (PUS && !push_acc) begin
            ovf_d = 1'b1;
         end
         if (POP && !pop_acc) begin
            udf_d = 1'b1;
         end
      end
   end

   // Control state register with asynchronous clear.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         head_q <= '0;
         rear_q <= '0;
         cnt_q  <= '0;
         ovf_q  <= 1'b0;
         udf_q  <= 1'b0;
      end else begin
         head_q <= head_d;
         rear_q <= rear_d;
         cnt_q  <= cnt_d;
         ovf_q  <= ovf_d;
         udf_q  <= udf_d;
      end
   end

   // Storage write; contents survive reset and flush by design.
   always_ff @(posedge CLK) begin
      if (wr_en) begin
         mem_q[rear_q] <= DI;
      end
   end

   // Output drive: head word falls through, forced to zero when empty.
   always_comb begin
      DF  = not_empty;
      FUL = is_full;
      AF  = (cnt_q >= AF_C);
      AE  = (cnt_q <= AE_C);
      CNT = cnt_q;
      OVF = ovf_q;
      UDF = udf_q;
      DO  = not_empty ? mem_q[head_q] : '0;
   end

endmodule

// File: doc/sync_queue.md
SYNC_QUEUE -- requirements
Module: sync_queue

Interface
REQ-001 Parameter BITSIZE, default 8, data word width in bits (>=1).
REQ-002 Parameter ADDSIZE, default 4, address width; DEPTH = 2**ADDSIZE entries (ADDSIZE>=1).
REQ-003 Parameter AF_LVL, default 2**ADDSIZE-2, almost-full threshold, legal range 1..DEPTH.
REQ-004 Parameter AE_LVL, default 2, almost-empty threshold, legal range 0..DEPTH-1.
REQ-005 CLK  input  1  clock; all state changes on rising edge.
REQ-006 RSTN  input  1  asynchronous active-low reset.
REQ-007 CLR  input  1  synchronous flush; also clears sticky error flags.
REQ-008 PUS  input  1  push request, sampled on rising CLK.
REQ-009 POP  input  1  pop request, sampled on rising CLK.
REQ-010 DI  input  BITSIZE  push data.
REQ-011 DO  output  BITSIZE  head word, first-word fall-through.
REQ-012 DF  output  1  data available (not empty).
REQ-013 FUL  output  1  queue holds DEPTH words.
REQ-014 AF  output  1  almost full.
REQ-015 AE  output  1  almost empty.
REQ-016 CNT  output  ADDSIZE+1  number of stored words, 0..DEPTH.
REQ-017 OVF  output  1  sticky overflow: push rejected.
REQ-018 UDF  output  1  sticky underflow: pop rejected.

Function
REQ-019 Block SHALL be fully synchronous to CLK except RSTN; PUS/POP SHALL be level requests, one action per asserted cycle, not edge-triggered.
REQ-020 Push SHALL be accepted iff PUS=1 and (FUL=0 or pop accepted same cycle); accepted push writes DI to mem[rear], rear advances by 1 modulo DEPTH.
REQ-021 Pop SHALL be accepted iff POP=1 and DF=1; head advances by 1 modulo DEPTH.
REQ-022 CNT SHALL update next cycle: +1 push only, -1 pop only, unchanged for both or neither.
REQ-023 Full and PUS=POP=1: both accepted, CNT stays DEPTH, OVF not set.
REQ-024 Empty and PUS=POP=1: push accepted, pop rejected, UDF set, CNT becomes 1.
REQ-025 PUS=1 with FUL=1 and no accepted pop: word dropped, state unchanged, OVF set to 1 next cycle.
REQ-026 POP=1 with DF=0: state unchanged, UDF set to 1 next cycle.
REQ-027 OVF and UDF SHALL stay 1 until CLR or reset.
REQ-028 Status outputs SHALL derive combinationally from registered CNT: DF = CNT!=0, FUL = CNT==DEPTH, AF = CNT>=AF_LVL, AE = CNT<=AE_LVL.
REQ-029 DO SHALL equal mem[head] when DF=1 and all zeros when DF=0; a word pushed into an empty queue appears on DO the cycle after the push edge (latency 1).
REQ-030 CLR=1 SHALL override PUS/POP that cycle: head=rear=0, CNT=0, OVF=UDF=0 next cycle; memory contents not cleared.
REQ-031 Pointer wrap SHALL be seamless: order preserved across any number of wraps.
REQ-032 Out-of-range parameters SHALL be rejected at elaboration (simulation fatal).

Reset
REQ-033 RSTN=0 SHALL immediately, independent of CLK, force head=rear=0, CNT=0, OVF=UDF=0, hence DF=0, FUL=0, AF=0 (AF_LVL>=1), AE=1, DO=0.
REQ-034 Memory array SHALL not be reset; reset asserted mid-transfer discards all contents and in-flight requests; first push after RSTN release is accepted normally.

Verification (BITSIZE=8, ADDSIZE=2, DEPTH=4, AF_LVL=3, AE_LVL=1)
REQ-035 Push 0x11,0x22,0x33,0x44 on 4 cycles -> CNT 1,2,3,4; AF=1 at CNT=3; FUL=1 at 4; DO=0x11 throughout; OVF=0.
REQ-036 From full, PUS with DI=0x55, POP=0 -> OVF=1, CNT=4; then pop 4 times -> DO 0x11,0x22,0x33,0x44, DF=0, DO=0x00, OVF still 1.
REQ-037 Empty, PUS=POP=1 with DI=0xA5 -> CNT=1, DO=0xA5, UDF=1; CLR one cycle -> CNT=0, UDF=0, DF=0.
REQ-038 Full, PUS=POP=1 with DI=0x66 for 6 cycles -> CNT stays 4, no OVF, output order continues, pointers wrap, final drain order correct.
REQ-039 RSTN low mid-burst with CNT=2 and PUS=1 -> outputs reset without CLK edge; after release, push 0x77 -> CNT=1, DO=0x77.
